// File: rtl/led_matrix_pkg.sv
// Constants and types shared by the LED matrix frame writer and scan controller.
// Frame-buffer geometry, the RGB444 pixel layout and the writer's FSM states live here.
package led_matrix_pkg;

    localparam int COLS          = 96;
    localparam int ROWS_PER_BANK = 24;
    localparam int ADDR_W        = 12;
    localparam int PIX_W         = 12;
    localparam int R_OFS         = 8;
    localparam int G_OFS         = 4;
    localparam int B_OFS         = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_DONE
    } lfw_state_e;

    function automatic logic [PIX_W-1:0] pack_rgb444(input logic [3:0] r,
                                                     input logic [3:0] g,
                                                     input logic [3:0] b);
        logic [PIX_W-1:0] p;
        p = '0;
        p[R_OFS +: 4] = r;
        p[G_OFS +: 4] = g;
        p[B_OFS +: 4] = b;
        return p;
    endfunction

endpackage

// File: rtl/led_pixel_assembler.sv
// Packs byte pairs into RGB444 pixels. Byte phase comes from the writer FSM;
// this block holds the red nibble and decodes start/resync/pixel events.
module led_pixel_assembler (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic                            i_accept,
    input  logic [7:0]                      i_byte,
    input  logic                            i_sof,
    input  logic                            i_in_frame,
    input  logic                            i_lo_phase,
    output logic                            o_start,
    output logic                            o_resync,
    output logic                            o_pix_vld,
    output logic [led_matrix_pkg::PIX_W-1:0] o_pix
);
    import led_matrix_pkg::*;

    logic [3:0] r_q;

    // Any SOF byte is a byte 0, whatever phase we were in.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_accept && (i_sof || (i_in_frame && !i_lo_phase))) begin
            r_q <= i_byte[3:0];
        end
    end

    assign o_start   = i_accept & i_sof;
    assign o_resync  = o_start & i_in_frame;
    assign o_pix_vld = i_accept & ~i_sof & i_in_frame & i_lo_phase;
    assign o_pix     = pack_rgb444(r_q, i_byte[7:4], i_byte[3:0]);

endmodule

// File: rtl/led_frame_writer.sv
// Byte-stream to dual-bank frame-buffer writer: owns the frame FSM, the pixel
// counter / bank bit and the registered RAM write port.
module led_frame_writer #(
    parameter int COLS          = led_matrix_pkg::COLS,
    parameter int ROWS_PER_BANK = led_matrix_pkg::ROWS_PER_BANK,
    parameter int ADDR_W        = led_matrix_pkg::ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    input  logic              i_sof,
    output logic              o_byte_ready,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [11:0]       o_ram_wr_data,
    output logic              o_ram_b1_we,
    output logic              o_ram_b2_we,
    output logic              o_frame_done,
    output logic              o_sync_err,
    output logic              o_busy
);
    import led_matrix_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(COLS * ROWS_PER_BANK - 1);

    lfw_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              bank_q;
    logic [ADDR_W-1:0] addr_q;
    logic [PIX_W-1:0]  data_q;
    logic              we1_q, we2_q, done_q, err_q;

    logic             accept, in_frame, lo_phase;
    logic             start, resync, pix_vld;
    logic [PIX_W-1:0] pix;

    assign in_frame = (state_q == S_HI) || (state_q == S_LO);
    assign lo_phase = (state_q == S_LO);
    assign accept   = i_byte_valid && o_byte_ready;

    led_pixel_assembler u_asm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_accept   (accept),
        .i_byte     (i_byte),
        .i_sof      (i_sof),
        .i_in_frame (in_frame),
        .i_lo_phase (lo_phase),
        .o_start    (start),
        .o_resync   (resync),
        .o_pix_vld  (pix_vld),
        .o_pix      (pix)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            we1_q   <= 1'b0;
            we2_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we1_q  <= 1'b0;
            we2_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            // SOF outranks everything, including a would-be final pixel.
            if (start) begin
                state_q <= S_LO;
                cnt_q   <= '0;
                bank_q  <= 1'b0;
                err_q   <= resync;
            end else begin
                case (state_q)
                    S_HI: if (accept) state_q <= S_LO;
                    S_LO: begin
                        if (pix_vld) begin
                            addr_q <= cnt_q;
                            data_q <= pix;
                            we1_q  <= ~bank_q;
                            we2_q  <= bank_q;
                            if (bank_q && cnt_q == LAST_PIX) begin
                                state_q <= S_DONE;
                            end else begin
                                state_q <= S_HI;
                                if (cnt_q == LAST_PIX) begin
                                    cnt_q  <= '0;
                                    bank_q <= 1'b1;
                                end else begin
                                    cnt_q <= cnt_q + ADDR_W'(1);
                                end
                            end
                        end
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_byte_ready  = (state_q != S_DONE);
    assign o_busy        = in_frame;
    assign o_ram_addr    = addr_q;
    assign o_ram_wr_data = data_q;
    assign o_ram_b1_we   = we1_q;
    assign o_ram_b2_we   = we2_q;
    assign o_frame_done  = done_q;
    assign o_sync_err    = err_q;

endmodule

// File: tb/tb_led_frame_writer.sv
// Randomized bench for led_frame_writer against a pixel-index model of the byte stream.
module tb_led_frame_writer;
    import led_matrix_pkg::*;

    localparam int NPB  = COLS * ROWS_PER_BANK;
    localparam int NPIX = 2 * NPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_v;
    logic        vld, sof;
    logic        ready, we1, we2, done, err, busy;
    logic [ADDR_W-1:0] addr;
    logic [11:0] wdata;

    led_frame_writer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_byte        (byte_v),
        .i_byte_valid  (vld),
        .i_sof         (sof),
        .o_byte_ready  (ready),
        .o_ram_addr    (addr),
        .o_ram_wr_data (wdata),
        .o_ram_b1_we   (we1),
        .o_ram_b2_we   (we2),
        .o_frame_done  (done),
        .o_sync_err    (err),
        .o_busy        (busy)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    // Model: frame progress as pixel index k; bank and address derive from k.
    bit         m_active, m_have_r, m_dstate;
    logic [3:0] m_r;
    int         m_k;
    bit         e_we1, e_we2, e_done, e_err, e_ready, e_busy;
    int         e_addr, e_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_have_r = 0; m_dstate = 0; m_r = '0; m_k = 0;
        e_we1 = 0; e_we2 = 0; e_done = 0; e_err = 0; e_ready = 1; e_busy = 0;
        e_addr = 0; e_data = 0;
    endtask

    task automatic model_edge(input bit acc, input logic [7:0] b, input bit s);
        e_we1 = 0; e_we2 = 0; e_err = 0;
        e_done = m_dstate;
        m_dstate = 0;
        if (acc) begin
            if (s) begin
                e_err = m_active;
                m_active = 1; m_have_r = 1; m_r = b[3:0]; m_k = 0;
            end else if (m_active) begin
                if (!m_have_r) begin
                    m_r = b[3:0]; m_have_r = 1;
                end else begin
                    e_we1 = (m_k < NPB);
                    e_we2 = !e_we1;
                    e_addr = m_k % NPB;
                    e_data = {20'd0, m_r, b};
                    m_have_r = 0;
                    m_k++;
                    if (m_k == NPIX) begin
                        m_active = 0; m_dstate = 1;
                    end
                end
            end
        end
        e_ready = !m_dstate;
        e_busy  = m_active;
    endtask

    task automatic check_outs();
        chk("ready", ready, e_ready);
        chk("busy",  busy,  e_busy);
        chk("b1_we", we1,   e_we1);
        chk("b2_we", we2,   e_we2);
        chk("addr",  addr,  e_addr);
        chk("wdata", wdata, e_data);
        chk("done",  done,  e_done);
        chk("sync_err", err, e_err);
    endtask

    // Entered and left just after a falling edge.
    task automatic step(input bit v, input logic [7:0] b, input bit s, output bit acc);
        vld = v; byte_v = b; sof = s;
        acc = v && e_ready;
        @(posedge clk);
        model_edge(acc, b, s);
        @(negedge clk);
        check_outs();
        vld = 0; sof = 0;
    endtask

    task automatic send(input logic [7:0] b, input bit s, input int gap);
        bit acc;
        int tries;
        for (int i = 0; i < gap; i++) step(0, 8'h00, 0, acc);
        tries = 0;
        do begin
            step(1, b, s, acc);
            tries++;
        end while (!acc && tries < 8);
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_pix(input logic [11:0] p, input bit s, input int maxgap);
        logic [3:0] junk;
        junk = 4'($urandom);
        send({junk, p[11:8]}, s, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
        send(p[7:0], 0, (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        logic [31:0] kv;
        rst = 1; vld = 0; sof = 0; byte_v = '0;
        model_reset();
        @(negedge clk);
        check_outs();
        @(negedge clk);
        rst = 0;

        // Bytes without SOF while idle are dropped.
        for (int i = 0; i < 10; i++) send(8'hAA, 0, 0);

        // Full frame back to back, pixel k = k[11:0].
        for (int k = 0; k < NPIX; k++) begin
            kv = k;
            send_pix(kv[11:0], k == 0, 0);
        end
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, acc);

        // 101 bytes then an early SOF, followed by a gapped random frame.
        for (int i = 0; i < 101; i++) send(8'($urandom), i == 0, 0);
        for (int k = 0; k < NPIX; k++) send_pix(12'($urandom), k == 0, 3);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, acc);

        // SOF lands on what would have been the final byte of the frame.
        for (int k = 0; k < NPIX - 1; k++) send_pix(12'($urandom), k == 0, 0);
        send(8'($urandom), 0, 0);
        send(8'($urandom), 1, 0);
        send(8'($urandom), 0, 1);

        // Async reset while the strobe for pixel 1000 is high.
        for (int k = 1; k <= 1000; k++) send_pix(12'($urandom), 0, 0);
        chk("pix1000_strobe", we1, 1);
        #1 rst = 1;
        #1 model_reset();
        check_outs();
        @(negedge clk);
        check_outs();
        rst = 0;
        for (int k = 0; k < 4; k++) send_pix(12'($urandom), k == 0, 1);
        for (int i = 0; i < 2; i++) step(0, 8'h00, 0, acc);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
